// File: rtl/env_voice_mod_if.sv
// Request/result bundle between the oscillator scheduler and env_voice_mod.
// The scheduler drives the request side; the envelope block answers with ready/valid/results.
interface env_voice_mod_if #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 10,
    parameter int ENV_W      = 8,
    parameter int RATE_W     = 4
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                       start_i;
    logic [VIDX_W-1:0]          voice_idx_i;
    logic                       gate_i;
    logic [RATE_W-1:0]          attack_i;
    logic [RATE_W-1:0]          decay_i;
    logic [3:0]                 sustain_i;
    logic [RATE_W-1:0]          release_i;
    logic signed [SAMPLE_W-1:0] sample_i;
    logic                       ready_o;
    logic                       valid_o;
    logic signed [SAMPLE_W-1:0] sample_o;
    logic [ENV_W-1:0]           env_o;

    modport master (
        output start_i, voice_idx_i, gate_i, attack_i, decay_i, sustain_i, release_i, sample_i,
        input  ready_o, valid_o, sample_o, env_o
    );

    modport slave (
        input  start_i, voice_idx_i, gate_i, attack_i, decay_i, sustain_i, release_i, sample_i,
        output ready_o, valid_o, sample_o, env_o
    );
endinterface

// File: rtl/env_voice_mod.sv
// Time-multiplexed multi-voice ADSR envelope with a bit-serial shift-add gain stage.
// One request ticks one voice's envelope and returns its sample scaled by the new level.
module env_voice_mod #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 10,
    parameter int ENV_W      = 8,
    parameter int RATE_W     = 4
) (
    input logic            clk_i,
    input logic            rst_ni,
    env_voice_mod_if.slave bus
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PRE_W  = (2 ** RATE_W) - 1;
    localparam int ACC_W  = SAMPLE_W + ENV_W;
    localparam int CNT_W  = $clog2(ENV_W) + 1;
    localparam logic [ENV_W-1:0]  ENV_MAX = '1;
    localparam logic [VIDX_W:0]   NV_L    = (VIDX_W + 1)'(NUM_VOICES);

    typedef enum logic [1:0] {S_IDLE, S_ENV, S_MUL, S_DONE} state_t;
    typedef enum logic [2:0] {PH_IDLE, PH_ATTACK, PH_DECAY, PH_SUSTAIN, PH_RELEASE} phase_t;

    function automatic logic signed [SAMPLE_W-1:0] floor_scale(input logic signed [ACC_W-1:0] acc);
        return SAMPLE_W'(acc >>> ENV_W);
    endfunction

    function automatic logic [PRE_W-1:0] rate_thr(input logic [RATE_W-1:0] rate);
        return PRE_W'((32'd1 << rate) - 32'd1);
    endfunction

    state_t state_q, state_d;

    logic [ENV_W-1:0] env_q   [NUM_VOICES];
    phase_t           phase_q [NUM_VOICES];
    logic [PRE_W-1:0] pre_q   [NUM_VOICES];
    logic             gate_q  [NUM_VOICES];

    logic [VIDX_W-1:0]          idx_p0;
    logic                       gate_p0;
    logic [RATE_W-1:0]          atk_p0, dcy_p0, rel_p0;
    logic [3:0]                 sus_p0;
    logic signed [SAMPLE_W-1:0] smp_p0;

    logic signed [ACC_W-1:0] mcand_p1, acc_p1;
    logic [ENV_W-1:0]        mplier_p1, env_p1;
    logic [CNT_W-1:0]        cnt_p1;

    logic                       vld_p2;
    logic signed [SAMPLE_W-1:0] sample_p2;
    logic [ENV_W-1:0]           env_p2;

    logic              idx_ok;
    logic [VIDX_W-1:0] vidx;
    logic [ENV_W-1:0]  sus_lvl, env_n;
    phase_t            ph_n;
    logic [PRE_W-1:0]  pre_n, thr;
    logic [RATE_W-1:0] rate_sel;
    logic              step;

    assign idx_ok  = ({1'b0, idx_p0} < NV_L);
    assign vidx    = idx_ok ? idx_p0 : '0;
    assign sus_lvl = {(ENV_W / 4){sus_p0}};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_ENV;
            S_ENV:   state_d = S_MUL;
            S_MUL:   if (cnt_p1 == CNT_W'(ENV_W - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Envelope tick: gate edges first, then prescaler, then the per-phase step.
    always_comb begin
        env_n    = env_q[vidx];
        ph_n     = phase_q[vidx];
        pre_n    = pre_q[vidx];
        rate_sel = '0;
        step     = 1'b0;
        if (gate_p0 && !gate_q[vidx]) begin
            ph_n  = PH_ATTACK;
            pre_n = '0;
        end else if (!gate_p0 && gate_q[vidx]) begin
            ph_n  = PH_RELEASE;
            pre_n = '0;
        end
        case (ph_n)
            PH_ATTACK:  rate_sel = atk_p0;
            PH_DECAY:   rate_sel = dcy_p0;
            PH_RELEASE: rate_sel = rel_p0;
            default:    rate_sel = '0;
        endcase
        thr = rate_thr(rate_sel);
        if (ph_n != PH_IDLE && ph_n != PH_SUSTAIN) begin
            if (pre_n >= thr) begin
                step  = 1'b1;
                pre_n = '0;
            end else begin
                pre_n = pre_n + 1'b1;
            end
        end
        if (step) begin
            case (ph_n)
                PH_ATTACK: begin
                    if (env_n != ENV_MAX) env_n = env_n + 1'b1;
                    if (env_n == ENV_MAX) ph_n = PH_DECAY;
                end
                PH_DECAY: begin
                    if (env_n > sus_lvl) env_n = env_n - 1'b1;
                    if (env_n <= sus_lvl) ph_n = PH_SUSTAIN;
                end
                PH_RELEASE: begin
                    if (env_n != '0) env_n = env_n - 1'b1;
                    if (env_n == '0) ph_n = PH_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_p1    <= '0;
            vld_p2    <= 1'b0;
            sample_p2 <= '0;
            env_p2    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                env_q[v]   <= '0;
                phase_q[v] <= PH_IDLE;
                pre_q[v]   <= '0;
                gate_q[v]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            vld_p2  <= (state_q == S_DONE);
            if (state_q == S_ENV) begin
                cnt_p1 <= '0;
                if (idx_ok) begin
                    env_q[idx_p0]   <= env_n;
                    phase_q[idx_p0] <= ph_n;
                    pre_q[idx_p0]   <= pre_n;
                    gate_q[idx_p0]  <= gate_p0;
                end
            end
            if (state_q == S_MUL) cnt_p1 <= cnt_p1 + 1'b1;
            if (state_q == S_DONE) begin
                sample_p2 <= floor_scale(acc_p1);
                env_p2    <= env_p1;
            end
        end
    end

    // Stage 0: request capture. Stage 1: serial multiply, LSB of the level first.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && bus.start_i) begin
            idx_p0  <= bus.voice_idx_i;
            gate_p0 <= bus.gate_i;
            atk_p0  <= bus.attack_i;
            dcy_p0  <= bus.decay_i;
            sus_p0  <= bus.sustain_i;
            rel_p0  <= bus.release_i;
            smp_p0  <= bus.sample_i;
        end
        if (state_q == S_ENV) begin
            env_p1    <= idx_ok ? env_n : '0;
            mplier_p1 <= idx_ok ? env_n : '0;
            mcand_p1  <= {{ENV_W{smp_p0[SAMPLE_W-1]}}, smp_p0};
            acc_p1    <= '0;
        end
        if (state_q == S_MUL) begin
            if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
            mcand_p1  <= mcand_p1 <<< 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

    // Stage 2: registered results and the one-cycle valid pulse.
    assign bus.ready_o  = (state_q == S_IDLE);
    assign bus.valid_o  = vld_p2;
    assign bus.sample_o = sample_p2;
    assign bus.env_o    = env_p2;
endmodule

// File: tb/tb_env_voice_mod.sv
// Scoreboard bench for env_voice_mod: a behavioural ADSR model queues expected
// results at each accepted request; a monitor pops and compares on every valid_o.
module tb_env_voice_mod;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    int   exp_env_q[$];
    int   exp_smp_q[$];

    int   m_env   [4];
    int   m_phase [4];
    int   m_pre   [4];
    int   m_gate  [4];

    int   last_env;
    int   last_smp;

    localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    env_voice_mod_if #(.NUM_VOICES(3), .SAMPLE_W(10), .ENV_W(8), .RATE_W(4)) bus ();

    env_voice_mod #(.NUM_VOICES(3), .SAMPLE_W(10), .ENV_W(8), .RATE_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_env[v] = 0; m_phase[v] = P_IDLE; m_pre[v] = 0; m_gate[v] = 0;
        end
    endtask

    task automatic model_req(input int idx, input int gate, input int a, input int d,
                             input int s, input int r, input int smp,
                             output int e_env, output int e_smp);
        int env, ph, pre, rate, lvl;
        if (idx >= 3) begin
            e_env = 0; e_smp = 0;
            return;
        end
        env = m_env[idx]; ph = m_phase[idx]; pre = m_pre[idx];
        lvl = s * 17;
        if (gate == 1 && m_gate[idx] == 0) begin ph = P_ATK; pre = 0; end
        if (gate == 0 && m_gate[idx] == 1) begin ph = P_REL; pre = 0; end
        rate = (ph == P_ATK) ? a : (ph == P_DEC) ? d : r;
        if (ph == P_ATK || ph == P_DEC || ph == P_REL) begin
            if (pre < (1 << rate) - 1) begin
                pre = pre + 1;
            end else begin
                pre = 0;
                if (ph == P_ATK) begin
                    env = (env < 255) ? env + 1 : 255;
                    if (env == 255) ph = P_DEC;
                end else if (ph == P_DEC) begin
                    if (env <= lvl) ph = P_SUS;
                    else begin
                        env = env - 1;
                        if (env == lvl) ph = P_SUS;
                    end
                end else begin
                    if (env > 0) env = env - 1;
                    if (env == 0) ph = P_IDLE;
                end
            end
        end
        m_env[idx] = env; m_phase[idx] = ph; m_pre[idx] = pre; m_gate[idx] = gate;
        e_env = env;
        e_smp = (smp * env) >>> 8;
    endtask

    // One request: drive on a falling edge, measure latency, optionally pulse a busy start.
    task automatic do_req(input int idx, input int gate, input int a, input int d,
                          input int s, input int r, input int smp, input bit busy);
        int e_env, e_smp, cyc;
        bit got;
        @(negedge clk);
        cyc = 0;
        while (bus.ready_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ready_wait", bus.ready_o, 1);
        bus.voice_idx_i = 2'(idx);
        bus.gate_i      = gate[0];
        bus.attack_i    = 4'(a);
        bus.decay_i     = 4'(d);
        bus.sustain_i   = 4'(s);
        bus.release_i   = 4'(r);
        bus.sample_i    = 10'(smp);
        bus.start_i     = 1'b1;
        model_req(idx, gate, a, d, s, r, smp, e_env, e_smp);
        exp_env_q.push_back(e_env);
        exp_smp_q.push_back(e_smp);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && cyc == 4) begin
                bus.voice_idx_i = 2'd2;
                bus.gate_i      = 1'b1;
                bus.attack_i    = 4'd0;
                bus.start_i     = 1'b1;
            end
            if (busy && cyc == 5) bus.start_i = 1'b0;
            if (bus.valid_o === 1'b1) got = 1'b1;
        end
        check_eq("latency", cyc, 10);
        last_env = int'(bus.env_o);
        last_smp = int'(bus.sample_o);
    endtask

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            if (exp_env_q.size() == 0) begin
                check_eq("stray_valid", 1, 0);
            end else begin
                check_eq("sb_env", int'(bus.env_o), exp_env_q.pop_front());
                check_eq("sb_sample", int'(bus.sample_o), exp_smp_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.voice_idx_i = '0; bus.gate_i = 1'b0;
        bus.attack_i = '0; bus.decay_i = '0; bus.sustain_i = '0;
        bus.release_i = '0; bus.sample_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.ready_o, 1);
        check_eq("rst_valid", bus.valid_o, 0);
        check_eq("rst_sample", int'(bus.sample_o), 0);
        check_eq("rst_env", int'(bus.env_o), 0);
        @(negedge clk) rst_n = 1'b1;

        // Attack at full rate on voice 0
        do_req(0, 1, 0, 0, 8, 0, 256, 1'b0);
        check_eq("atk_first_env", last_env, 1);
        check_eq("atk_first_smp", last_smp, 1);
        for (int i = 2; i <= 255; i++) do_req(0, 1, 0, 0, 8, 0, 256, 1'b0);
        check_eq("atk_peak_env", last_env, 255);
        check_eq("atk_peak_smp", last_smp, 255);

        // Decay to sustain 0x88, then hold while the sustain code changes
        for (int i = 1; i <= 119; i++) do_req(0, 1, 0, 0, 8, 0, -512, 1'b0);
        check_eq("dec_sus_env", last_env, 136);
        check_eq("dec_sus_smp", last_smp, -272);
        for (int i = 0; i < 3; i++) do_req(0, 1, 0, 0, 3, 0, -512, 1'b0);
        check_eq("sus_hold_env", last_env, 136);

        // Prescaled attack on voice 1
        for (int i = 1; i <= 8; i++) begin
            do_req(1, 1, 2, 0, 8, 0, 100, 1'b0);
            if (i == 3) check_eq("pre_env_3", last_env, 0);
            if (i == 4) check_eq("pre_env_4", last_env, 1);
            if (i == 7) check_eq("pre_env_7", last_env, 1);
        end
        check_eq("pre_env_8", last_env, 2);

        do_req(0, 1, 0, 0, 8, 0, 256, 1'b0);
        check_eq("iso_v0_env", last_env, 136);

        // Busy start is ignored; voice 2 must still see a clean rising edge
        do_req(0, 1, 0, 0, 8, 0, 256, 1'b1);
        check_eq("busy_v0_env", last_env, 136);
        repeat (15) @(posedge clk);
        do_req(2, 1, 3, 0, 8, 0, 200, 1'b0);
        check_eq("busy_v2_env", last_env, 0);

        do_req(3, 1, 0, 0, 8, 0, 300, 1'b0);
        check_eq("bad_idx_env", last_env, 0);
        check_eq("bad_idx_smp", last_smp, 0);
        do_req(0, 1, 0, 0, 8, 0, 256, 1'b0);
        check_eq("bad_idx_v0", last_env, 136);

        // Release voice 0 down to zero
        for (int i = 1; i <= 136; i++) begin
            do_req(0, 0, 0, 0, 8, 0, 100, 1'b0);
            if (i == 1) check_eq("rel_first_env", last_env, 135);
        end
        check_eq("rel_zero_env", last_env, 0);
        for (int i = 0; i < 2; i++) do_req(0, 0, 0, 0, 8, 0, 100, 1'b0);
        check_eq("rel_hold_env", last_env, 0);
        check_eq("rel_hold_smp", last_smp, 0);

        do_req(1, 1, 2, 0, 8, 0, 500, 1'b0);
        check_eq("v1_env", last_env, 2);
        check_eq("v1_smp", last_smp, 3);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.voice_idx_i = 2'd1; bus.gate_i = 1'b1; bus.sample_i = 10'sd500;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", bus.ready_o, 1);
        check_eq("mid_rst_valid", bus.valid_o, 0);
        check_eq("mid_rst_sample", int'(bus.sample_o), 0);
        check_eq("mid_rst_env", int'(bus.env_o), 0);
        exp_env_q.delete();
        exp_smp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);

        do_req(0, 1, 0, 0, 8, 0, 256, 1'b0);
        check_eq("post_rst_env", last_env, 1);
        check_eq("post_rst_smp", last_smp, 1);
        repeat (3) @(posedge clk);
        check_eq("sb_drained", exp_env_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
